pet_input_conditioner: RTL and testbench

- Front-end event stage sitting directly upstream of the animation/state controller.
- Synchronises and debounces the five navigation buttons and the raw touch sensor. Produces clean single-cycle button pulses plus the touched, petting, awaking and expecting signals the controller consumes.
- Contains the "pet wants attention" request timer, so the controller only reacts to clean events and levels.

---
 rtl/pet_input_conditioner_if.sv | 30 +++
 rtl/pet_input_conditioner.sv | 181 ++++++++++++++++++
 tb/tb_pet_input_conditioner.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pet_input_conditioner_if.sv
// Raw button/touch inputs and conditioned event outputs of the pet input conditioner.
// The master side drives the raw pads; the slave side is the conditioner itself.
interface pet_input_conditioner_if;
  logic btn_c_raw;
  logic btn_u_raw;
  logic btn_d_raw;
  logic btn_l_raw;
  logic btn_r_raw;
  logic touch_raw;

  logic pressed;
  logic up;
  logic down;
  logic left;
  logic right;
  logic touched;
  logic petting;
  logic awaking;
  logic expecting;

  modport master (
    output btn_c_raw, btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw, touch_raw,
    input  pressed, up, down, left, right, touched, petting, awaking, expecting
  );

  modport slave (
    input  btn_c_raw, btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw, touch_raw,
    output pressed, up, down, left, right, touched, petting, awaking, expecting
  );
endinterface

// File: rtl/pet_input_conditioner.sv
// Synchronises/debounces the five buttons and touch pad, derives petting and
// activity, and runs the attention-request timer for the animation controller.
//
// state | meaning
// WAIT  | counting idle cycles since the last user activity, expecting=0
// ASK   | pet requests attention, expecting=1 until answered or window expires
module pet_input_conditioner #(
  parameter int unsigned DEB_CNT       = 1_000_000,
  parameter int unsigned PET_HOLD      = 200_000_000,
  parameter int unsigned EXPECT_PERIOD = 2_000_000_000,
  parameter int unsigned EXPECT_WINDOW = 500_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  pet_input_conditioner_if.slave   bus
);

  localparam int N_IN  = 6;
  localparam int TOUCH = 5;

  localparam logic [31:0] DEB_LAST    = 32'(DEB_CNT - 1);
  localparam logic [31:0] HOLD_MAX    = 32'(PET_HOLD);
  localparam logic [31:0] PERIOD_LAST = 32'(EXPECT_PERIOD - 1);
  localparam logic [31:0] WINDOW_LAST = 32'(EXPECT_WINDOW - 1);

  typedef enum logic {
    S_WAIT = 1'b0,
    S_ASK  = 1'b1
  } state_t;

  // bit order: 0=centre, 1=up, 2=down, 3=left, 4=right, 5=touch
  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] sync_1;
  logic [N_IN-1:0] sync_2;
  logic [N_IN-1:0] stable;
  logic [N_IN-1:0] stable_q;
  logic [31:0]     deb_cnt [N_IN];

  logic [4:0]      btn_pulse;
  logic            touched;
  logic            touched_q;
  logic [31:0]     hold_cnt;
  logic            petting;
  logic            petting_q;
  logic            pet_fall;
  logic            activity;
  logic            awaking;

  state_t          state, state_nxt;
  logic [31:0]     idle_cnt, idle_cnt_nxt;
  logic [31:0]     win_cnt, win_cnt_nxt;

  assign raw_in = {bus.touch_raw, bus.btn_r_raw, bus.btn_l_raw,
                   bus.btn_d_raw, bus.btn_u_raw, bus.btn_c_raw};

  // Two-flop synchroniser; nothing downstream looks at raw_in directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= raw_in;
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < N_IN; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync_2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= ~stable[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q  <= '0;
      btn_pulse <= '0;
      touched   <= 1'b0;
      touched_q <= 1'b0;
    end else begin
      stable_q  <= stable;
      btn_pulse <= stable[4:0] & ~stable_q[4:0];
      touched   <= stable[TOUCH];
      touched_q <= touched;
    end
  end

  // Hold counter saturates so petting stays up for as long as the touch lasts.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= '0;
      petting_q <= 1'b0;
    end else begin
      petting_q <= petting;
      if (!touched) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 32'd1;
      end
    end
  end

  assign petting  = (hold_cnt == HOLD_MAX);
  assign pet_fall = petting_q & ~petting;
  assign activity = (|btn_pulse) | (touched & ~touched_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      awaking <= 1'b0;
    end else begin
      awaking <= activity;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_WAIT;
      idle_cnt <= '0;
      win_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
      win_cnt  <= win_cnt_nxt;
    end
  end

  // Activity in the expiry cycle wins, so the pet never asks right after a press.
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    win_cnt_nxt  = win_cnt;
    case (state)
      S_WAIT: begin
        if (activity) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt == PERIOD_LAST) begin
          state_nxt   = S_ASK;
          win_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = idle_cnt + 32'd1;
        end
      end
      S_ASK: begin
        if (btn_pulse[0] || pet_fall || (win_cnt == WINDOW_LAST)) begin
          state_nxt    = S_WAIT;
          idle_cnt_nxt = '0;
        end else if (!petting) begin
          win_cnt_nxt = win_cnt + 32'd1;
        end
      end
      default: begin
        state_nxt    = S_WAIT;
        idle_cnt_nxt = '0;
      end
    endcase
  end

  assign bus.pressed   = btn_pulse[0];
  assign bus.up        = btn_pulse[1];
  assign bus.down      = btn_pulse[2];
  assign bus.left      = btn_pulse[3];
  assign bus.right     = btn_pulse[4];
  assign bus.touched   = touched;
  assign bus.petting   = petting;
  assign bus.awaking   = awaking;
  assign bus.expecting = (state == S_ASK);

endmodule

// File: tb/tb_pet_input_conditioner.sv
// Bench for pet_input_conditioner: directed scenario timing checks plus a long
// randomized run compared cycle-by-cycle against a behavioural model.
module tb_pet_input_conditioner;

  localparam int DEB = 4;
  localparam int PH  = 16;
  localparam int EP  = 50;
  localparam int EW  = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pet_input_conditioner_if bus ();

  pet_input_conditioner #(
    .DEB_CNT       (DEB),
    .PET_HOLD      (PH),
    .EXPECT_PERIOD (EP),
    .EXPECT_WINDOW (EW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Behavioural model: raw samples reach the debouncer two cycles late; a level
  // is accepted after DEB consecutive disagreeing samples.
  logic [5:0] m_pipe[$] = '{6'd0, 6'd0};
  int         m_run[6];
  bit [5:0]   m_lvl, m_lvl_d;
  bit [4:0]   m_pulse;
  bit         m_touched, m_touched_d, m_awaking, m_pet_d, m_ask;
  int         m_hold, m_idle, m_win;

  function automatic logic [5:0] raw_vec();
    return {bus.touch_raw, bus.btn_r_raw, bus.btn_l_raw,
            bus.btn_d_raw, bus.btn_u_raw, bus.btn_c_raw};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bus.pressed, bus.up, bus.down, bus.left, bus.right,
            bus.touched, bus.petting, bus.awaking, bus.expecting};
  endfunction

  function automatic logic [8:0] model_vec();
    return {m_pulse[0], m_pulse[1], m_pulse[2], m_pulse[3], m_pulse[4],
            m_touched, (m_hold == PH), m_awaking, m_ask};
  endfunction

  task automatic model_step();
    logic [5:0] seen;
    bit [5:0]   lvl_n;
    bit         act, pet_now, pet_fall;
    if (rst) begin
      m_pipe.delete();
      m_pipe.push_back(6'd0);
      m_pipe.push_back(6'd0);
      for (int i = 0; i < 6; i++) m_run[i] = 0;
      m_lvl = '0; m_lvl_d = '0; m_pulse = '0;
      m_touched = 0; m_touched_d = 0; m_awaking = 0; m_pet_d = 0; m_ask = 0;
      m_hold = 0; m_idle = 0; m_win = 0;
    end else begin
      seen = m_pipe.pop_front();
      m_pipe.push_back(raw_vec());
      lvl_n = m_lvl;
      for (int i = 0; i < 6; i++) begin
        if (seen[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            lvl_n[i] = ~m_lvl[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      pet_now  = (m_hold == PH);
      act      = (|m_pulse) || (m_touched && !m_touched_d);
      pet_fall = m_pet_d && !pet_now;
      if (!m_ask) begin
        if (act) m_idle = 0;
        else if (m_idle == EP - 1) begin m_ask = 1; m_win = 0; end
        else m_idle++;
      end else begin
        if (m_pulse[0] || pet_fall || m_win == EW - 1) begin m_ask = 0; m_idle = 0; end
        else if (!pet_now) m_win++;
      end
      m_awaking   = act;
      m_pet_d     = pet_now;
      m_hold      = m_touched ? ((m_hold < PH) ? m_hold + 1 : PH) : 0;
      m_touched_d = m_touched;
      m_touched   = m_lvl[5];
      m_pulse     = m_lvl[4:0] & ~m_lvl_d[4:0];
      m_lvl_d     = m_lvl;
      m_lvl       = lvl_n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic set_raw(input logic [5:0] v);
    bus.btn_c_raw = v[0];
    bus.btn_u_raw = v[1];
    bus.btn_d_raw = v[2];
    bus.btn_l_raw = v[3];
    bus.btn_r_raw = v[4];
    bus.touch_raw = v[5];
  endtask

  task automatic do_reset();
    set_raw(6'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int busy;
    set_raw(6'b100010);
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (dut_vec() !== 9'd0) $display("FAIL reset_outputs: got %b, expected 000000000", dut_vec());
    else n_pass++;
    rst  = 1'b0;
    busy = 0;
    for (int n = 1; n <= DEB + 2; n++) begin
      tick();
      if (dut_vec() != 9'd0) busy++;
    end
    n_checks++;
    if (busy !== 0) $display("FAIL reset_release_quiet: got %0d active cycles, expected 0", busy);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_debounce();
    int ups, up_at, awk_at;
    do_reset();
    bus.btn_u_raw = 1'b1;
    repeat (3) tick();
    bus.btn_u_raw = 1'b0;
    ups = 0;
    repeat (15) begin
      tick();
      if (bus.up || bus.awaking) ups++;
    end
    n_checks++;
    if (ups !== 0) $display("FAIL glitch_rejected: got %0d pulses, expected 0", ups);
    else n_pass++;

    bus.btn_u_raw = 1'b1;
    ups = 0; up_at = -1; awk_at = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.up) begin ups++; if (up_at < 0) up_at = n; end
      if (bus.awaking && awk_at < 0) awk_at = n;
    end
    n_checks++;
    if (up_at !== 7) $display("FAIL up_latency: got %0d, expected 7", up_at);
    else n_pass++;
    n_checks++;
    if (ups !== 1) $display("FAIL up_single: got %0d pulses, expected 1", ups);
    else n_pass++;
    n_checks++;
    if (awk_at !== 8) $display("FAIL awaking_latency: got %0d, expected 8", awk_at);
    else n_pass++;

    bus.btn_u_raw = 1'b0;
    ups = 0;
    repeat (15) begin
      tick();
      if (bus.up || bus.awaking) ups++;
    end
    n_checks++;
    if (ups !== 0) $display("FAIL release_silent: got %0d pulses, expected 0", ups);
    else n_pass++;
  endtask

  task automatic test_touch();
    int t_rise, p_rise, t_fall, p_fall;
    do_reset();
    bus.touch_raw = 1'b1;
    t_rise = -1; p_rise = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (bus.touched && t_rise < 0) t_rise = n;
      if (bus.petting && p_rise < 0) p_rise = n;
    end
    n_checks++;
    if (t_rise !== 7) $display("FAIL touched_rise: got %0d, expected 7", t_rise);
    else n_pass++;
    n_checks++;
    if (p_rise !== 23) $display("FAIL petting_rise: got %0d, expected 23", p_rise);
    else n_pass++;

    bus.touch_raw = 1'b0;
    t_fall = -1; p_fall = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (!bus.touched && t_fall < 0) t_fall = n;
      if (!bus.petting && p_fall < 0) p_fall = n;
    end
    n_checks++;
    if (t_fall !== 7) $display("FAIL touched_fall: got %0d, expected 7", t_fall);
    else n_pass++;
    n_checks++;
    if (p_fall !== 8) $display("FAIL petting_fall: got %0d, expected 8", p_fall);
    else n_pass++;
  endtask

  task automatic test_expect_timeout();
    int rise1, fall1, rise2;
    do_reset();
    rise1 = -1; fall1 = -1; rise2 = -1;
    for (int n = 1; n <= 130; n++) begin
      tick();
      if (bus.expecting && rise1 < 0) rise1 = n;
      else if (!bus.expecting && rise1 >= 0 && fall1 < 0) fall1 = n;
      else if (bus.expecting && fall1 >= 0 && rise2 < 0) rise2 = n;
    end
    n_checks++;
    if (rise1 !== 50) $display("FAIL expect_rise: got %0d, expected 50", rise1);
    else n_pass++;
    n_checks++;
    if (fall1 !== 70) $display("FAIL expect_window: got %0d, expected 70", fall1);
    else n_pass++;
    n_checks++;
    if (rise2 !== 120) $display("FAIL expect_rearm: got %0d, expected 120", rise2);
    else n_pass++;
  endtask

  task automatic test_expect_press();
    int lefts, p_at, e_fall;
    do_reset();
    repeat (50) tick();
    bus.btn_l_raw = 1'b1;
    lefts = 0;
    repeat (9) begin
      tick();
      if (bus.left) lefts++;
    end
    n_checks++;
    if (lefts !== 1 || bus.expecting !== 1'b1)
      $display("FAIL left_in_ask: got left=%0d expecting=%b, expected left=1 expecting=1", lefts, bus.expecting);
    else n_pass++;

    bus.btn_l_raw = 1'b0;
    bus.btn_c_raw = 1'b1;
    p_at = -1; e_fall = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (bus.pressed && p_at < 0) p_at = n;
      if (!bus.expecting && e_fall < 0) e_fall = n;
    end
    bus.btn_c_raw = 1'b0;
    n_checks++;
    if (p_at !== 7) $display("FAIL press_latency: got %0d, expected 7", p_at);
    else n_pass++;
    n_checks++;
    if (e_fall !== 8) $display("FAIL press_answers: got %0d, expected 8", e_fall);
    else n_pass++;
  endtask

  task automatic test_pet_in_ask();
    int ask_at, drops, p_fall, e_fall;
    do_reset();
    bus.touch_raw = 1'b1;
    ask_at = -1;
    for (int n = 1; n <= 100 && ask_at < 0; n++) begin
      tick();
      if (bus.expecting) ask_at = n;
    end
    n_checks++;
    if (ask_at !== 58) $display("FAIL ask_while_petting: got %0d, expected 58", ask_at);
    else n_pass++;
    drops = 0;
    repeat (40) begin
      tick();
      if (!bus.expecting) drops++;
    end
    n_checks++;
    if (drops !== 0) $display("FAIL window_frozen: got %0d low cycles, expected 0", drops);
    else n_pass++;

    bus.touch_raw = 1'b0;
    p_fall = -1; e_fall = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (!bus.petting && p_fall < 0) p_fall = n;
      if (!bus.expecting && e_fall < 0) e_fall = n;
    end
    n_checks++;
    if (p_fall !== 8 || e_fall !== 9)
      $display("FAIL pet_session_answers: got petting_fall=%0d expect_fall=%0d, expected 8 and 9", p_fall, e_fall);
    else n_pass++;
  endtask

  task automatic test_reset_in_ask();
    int busy;
    do_reset();
    bus.touch_raw = 1'b1;
    repeat (60) tick();
    n_checks++;
    if (bus.expecting !== 1'b1 || bus.petting !== 1'b1)
      $display("FAIL ask_setup: got expecting=%b petting=%b, expected 1 1", bus.expecting, bus.petting);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if (dut_vec() !== 9'd0) $display("FAIL reset_in_ask: got %b, expected 000000000", dut_vec());
    else n_pass++;
    rst  = 1'b0;
    busy = 0;
    repeat (DEB + 2) begin
      tick();
      if (dut_vec() != 9'd0) busy++;
    end
    n_checks++;
    if (busy !== 0) $display("FAIL no_pulse_on_release: got %0d active cycles, expected 0", busy);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_simultaneous();
    int p_at, r_at;
    do_reset();
    bus.btn_c_raw = 1'b1;
    bus.btn_r_raw = 1'b1;
    p_at = -1; r_at = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (bus.pressed && p_at < 0) p_at = n;
      if (bus.right && r_at < 0) r_at = n;
    end
    set_raw(6'd0);
    n_checks++;
    if (p_at !== 7 || r_at !== 7)
      $display("FAIL simultaneous: got pressed=%0d right=%0d, expected 7 and 7", p_at, r_at);
    else n_pass++;
  endtask

  task automatic test_random();
    int         hold_left[6];
    logic [5:0] v;
    int         shown;
    do_reset();
    v = '0;
    shown = 0;
    for (int i = 0; i < 6; i++) hold_left[i] = 1;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 6; i++) begin
        hold_left[i]--;
        if (hold_left[i] <= 0) begin
          v[i] = ~v[i];
          hold_left[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 140))
                                                     : int'($urandom_range(1, 7));
        end
      end
      set_raw(v);
      rst = ($urandom_range(0, 799) == 0);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        if (shown < 10)
          $display("FAIL random_vs_model cyc=%0d: got %b, expected %b", cyc, dut_vec(), model_vec());
        shown++;
      end else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    set_raw(6'd0);
    test_reset();
    test_debounce();
    test_touch();
    test_expect_timeout();
    test_expect_press();
    test_pet_in_ask();
    test_reset_in_ask();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
